config_write_sequencer: RTL and testbench

- Write-side master for the watchdog configuration register bank. Drives its WREN/ABUS/DBUS write port.
- On a BOOT_START pulse it runs a fixed initialisation sequence: FWLEN, SWLEN, RST_LMT, then SERVICE with INIT set.
- Otherwise it accepts single host writes over a valid/ready handshake and serialises them with a programmable idle gap.
- Sits between the host/command logic and the configuration register.

---
 rtl/config_write_sequencer.sv | 155 +++++++++++++++
 tb/tb_config_write_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_write_sequencer.sv
// Write-side master for the watchdog configuration register bank: runs the fixed
// boot initialisation sequence and serialises single host writes with an idle gap.
module config_write_sequencer #(
  parameter logic [7:0]  FWLEN_INIT   = 8'd20,
  parameter logic [7:0]  SWLEN_INIT   = 8'd10,
  parameter logic [7:0]  RST_LMT_INIT = 8'd3,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BOOT_START,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [1:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       WREN,
  output logic [1:0] ABUS,
  output logic [7:0] DBUS,
  output logic       BUSY,
  output logic       BOOTED,
  output logic       BOOT_DONE,
  output logic [7:0] WR_COUNT,
  output logic [1:0] DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic        boot_q, boot_d;
  logic [3:0]  gap_q, gap_d;
  logic        wren_d;
  logic [1:0]  abus_d;
  logic [7:0]  dbus_d;
  logic        step;
  logic        accept;

  // Boot phase order is FW, SW, RL, SV; returns {address, data}.
  function automatic logic [9:0] boot_word(input logic [1:0] ph);
    case (ph)
      2'd0:    boot_word = {2'd0, FWLEN_INIT};
      2'd1:    boot_word = {2'd1, SWLEN_INIT};
      2'd2:    boot_word = {2'd3, RST_LMT_INIT};
      default: boot_word = {2'd2, 8'h10};
    endcase
  endfunction

  // Handshake: a request transfers on a rising edge where REQ_VALID && REQ_READY;
  // the host holds ADDR/DATA stable until then. BOOT_START takes priority.
  assign REQ_READY = (state_q == S_IDLE) && !BOOT_START;
  assign accept    = REQ_VALID && REQ_READY;
  assign DBG_STATE = state_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    boot_d  = boot_q;
    gap_d   = gap_q;
    wren_d  = 1'b0;
    abus_d  = 2'd0;
    dbus_d  = 8'd0;
    step    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (BOOT_START && !BOOTED) begin
          state_d          = S_WR;
          boot_d           = 1'b1;
          phase_d          = 2'd0;
          wren_d           = 1'b1;
          {abus_d, dbus_d} = boot_word(2'd0);
        end else if (accept) begin
          state_d = S_WR;
          boot_d  = 1'b0;
          wren_d  = 1'b1;
          abus_d  = REQ_ADDR;
          // SERVICE is ORed at the destination; bits 7:5 carry nothing.
          dbus_d  = (REQ_ADDR == 2'd2) ? {3'b000, REQ_DATA[4:0]} : REQ_DATA;
        end
      end
      S_WR: begin
        if (GAP_LD != 4'd0) begin
          state_d = S_GAP;
          gap_d   = GAP_LD;
        end else begin
          step = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d = 4'd0;
          step  = 1'b1;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (step) begin
      if (boot_q && (phase_q != 2'd3)) begin
        state_d          = S_WR;
        phase_d          = phase_q + 2'd1;
        wren_d           = 1'b1;
        {abus_d, dbus_d} = boot_word(phase_q + 2'd1);
      end else if (boot_q) begin
        state_d = S_DONE;
        boot_d  = 1'b0;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Outputs are registered from the next-state decode so they align with the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      phase_q   <= 2'd0;
      boot_q    <= 1'b0;
      gap_q     <= 4'd0;
      WREN      <= 1'b0;
      ABUS      <= 2'd0;
      DBUS      <= 8'd0;
      BUSY      <= 1'b0;
      BOOTED    <= 1'b0;
      BOOT_DONE <= 1'b0;
      WR_COUNT  <= 8'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      boot_q    <= boot_d;
      gap_q     <= gap_d;
      WREN      <= wren_d;
      ABUS      <= abus_d;
      DBUS      <= dbus_d;
      BUSY      <= (state_d != S_IDLE);
      BOOT_DONE <= (state_d == S_DONE);
      if (state_d == S_DONE) begin
        BOOTED <= 1'b1;
      end
      if (wren_d && (WR_COUNT != 8'hFF)) begin
        WR_COUNT <= WR_COUNT + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_config_write_sequencer.sv
// Bench for config_write_sequencer: directed boot/reset/handshake steps plus random
// single writes, scored against an ordered list of expected register writes.
module tb_config_write_sequencer;

  localparam int GAP = 1;
  localparam logic [7:0] FW = 8'd20;
  localparam logic [7:0] SW = 8'd10;
  localparam logic [7:0] RL = 8'd3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BOOT_START;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [1:0] REQ_ADDR;
  logic [7:0] REQ_DATA;
  logic       WREN;
  logic [1:0] ABUS;
  logic [7:0] DBUS;
  logic       BUSY;
  logic       BOOTED;
  logic       BOOT_DONE;
  logic [7:0] WR_COUNT;
  logic [1:0] DBG_STATE;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [9:0] exp_q[$];
  logic [9:0] wr_log_q[$];
  logic [7:0] wr_cnt_q[$];
  int         wr_cyc_q[$];
  int         bd_cyc_q[$];
  int         rd_idx = 0;
  int         exp_cnt = 0;
  int         idle_bad = 0;
  bit         mon_en = 1'b0;
  bit         model_booted = 1'b0;

  config_write_sequencer #(
    .FWLEN_INIT(FW), .SWLEN_INIT(SW), .RST_LMT_INIT(RL), .GAP_CYCLES(GAP)
  ) dut (
    .CLK(CLK), .RST(RST), .BOOT_START(BOOT_START),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .WREN(WREN), .ABUS(ABUS), .DBUS(DBUS),
    .BUSY(BUSY), .BOOTED(BOOTED), .BOOT_DONE(BOOT_DONE),
    .WR_COUNT(WR_COUNT), .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Bus observer: logs every write cycle and flags any dirty bus outside one.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (WREN === 1'b1) begin
        wr_log_q.push_back({ABUS, DBUS});
        wr_cnt_q.push_back(WR_COUNT);
        wr_cyc_q.push_back(cyc);
      end else if ((WREN !== 1'b0) || ({ABUS, DBUS} !== 10'd0)) begin
        idle_bad = idle_bad + 1;
      end
      if (BOOT_DONE === 1'b1) bd_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic sb_drain();
    logic [9:0] e;
    while (rd_idx < wr_log_q.size()) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", wr_log_q[rd_idx], 10'h3FF);
      end else begin
        e = exp_q.pop_front();
        check("sb_write", wr_log_q[rd_idx], e);
      end
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      check("sb_wr_count", wr_cnt_q[rd_idx], exp_cnt);
      rd_idx++;
    end
  endtask

  function automatic int wr_cyc_at(input int i);
    return (i < wr_cyc_q.size()) ? wr_cyc_q[i] : -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    sb_drain();
    RST = 1'b1; BOOT_START = 1'b0; REQ_VALID = 1'b0;
    repeat (2) tick();
    exp_q.delete();
    exp_cnt = 0;
    model_booted = 1'b0;
    RST = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic boot_pulse(output int t0);
    BOOT_START = 1'b1;
    #1;
    check("ready_forced_low", REQ_READY, 1'b0);
    t0 = cyc + 1;
    if (!model_booted) begin
      exp_q.push_back({2'd0, FW});
      exp_q.push_back({2'd1, SW});
      exp_q.push_back({2'd3, RL});
      exp_q.push_back({2'd2, 8'h10});
      model_booted = 1'b1;
    end
    tick();
    BOOT_START = 1'b0;
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d, output int ths);
    int k = 0;
    REQ_ADDR = a; REQ_DATA = d; REQ_VALID = 1'b1;
    #1;
    while ((REQ_READY !== 1'b1) && (k < 60)) begin
      tick();
      k++;
    end
    if (REQ_READY !== 1'b1) check("handshake_timeout", REQ_READY, 1'b1);
    ths = cyc + 1;
    exp_q.push_back({a, (a == 2'd2) ? (d & 8'h1F) : d});
    tick();
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin
      tick();
      k++;
    end while ((BUSY !== 1'b0) && (k < budget));
    check("idle_wait", BUSY, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int t0, ths, n0, nbd;
    logic [1:0] ra;
    logic [7:0] rd;
    RST = 1'b1; BOOT_START = 1'b0; REQ_VALID = 1'b0; REQ_ADDR = 2'd0; REQ_DATA = 8'd0;

    do_reset();
    @(negedge CLK);
    check("rst_wren", WREN, 1'b0);
    check("rst_bus", {ABUS, DBUS}, 10'd0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_booted", BOOTED, 1'b0);
    check("rst_boot_done", BOOT_DONE, 1'b0);
    check("rst_wr_count", WR_COUNT, 8'd0);
    check("rst_ready", REQ_READY, 1'b1);

    // Boot sequence timing: writes every (1+GAP) cycles, done one gap after the last.
    n0 = wr_cyc_q.size();
    nbd = bd_cyc_q.size();
    boot_pulse(t0);
    check("boot_busy", BUSY, 1'b1);
    wait_idle(40);
    for (int i = 0; i < 4; i++) check("boot_wr_offset", wr_cyc_at(n0 + i) - t0 + 1, 1 + i * (1 + GAP));
    check("boot_done_pulses", bd_cyc_q.size() - nbd, 1);
    if (bd_cyc_q.size() > nbd) check("boot_done_offset", bd_cyc_q[nbd] - t0 + 1, 4 * (1 + GAP) + 1);
    check("boot_booted", BOOTED, 1'b1);
    check("boot_wr_count", WR_COUNT, 8'd4);
    sb_drain();

    // Single write with turnaround.
    n0 = wr_cyc_q.size();
    host_write(2'd1, 8'h40, ths);
    check("single_ready_low0", REQ_READY, 1'b0);
    tick();
    check("single_ready_low1", REQ_READY, 1'b0);
    tick();
    check("single_ready_back", REQ_READY, 1'b1);
    check("single_wr_cycle", wr_cyc_at(n0), ths);
    check("single_wr_count", WR_COUNT, 8'd5);

    // SERVICE masking.
    host_write(2'd2, 8'hFF, ths);
    wait_idle(20);
    check("service_mask", wr_log_q[wr_log_q.size() - 1], {2'd2, 8'h1F});
    sb_drain();

    // Second boot request after BOOTED is ignored.
    n0 = wr_cyc_q.size();
    nbd = bd_cyc_q.size();
    boot_pulse(t0);
    repeat (12) tick();
    check("reboot_no_write", wr_cyc_q.size() - n0, 0);
    check("reboot_no_done", bd_cyc_q.size() - nbd, 0);
    check("reboot_wr_count", WR_COUNT, 8'd6);
    check("reboot_booted", BOOTED, 1'b1);

    // Boot and request in the same cycle: boot first, request after BOOT_DONE.
    do_reset();
    n0 = wr_cyc_q.size();
    REQ_ADDR = 2'd3; REQ_DATA = 8'h07; REQ_VALID = 1'b1;
    boot_pulse(t0);
    host_write(2'd3, 8'h07, ths);
    check("collide_handshake", ths - t0, 4 * (1 + GAP) + 2);
    wait_idle(20);
    check("collide_writes", wr_cyc_q.size() - n0, 5);
    check("collide_req_cycle", wr_cyc_at(n0 + 4), ths);
    check("collide_wr_count", WR_COUNT, 8'd5);
    sb_drain();

    // Reset in the gap after the SWLEN write abandons the boot.
    do_reset();
    boot_pulse(t0);
    repeat (3) tick();
    check("midrst_busy", BUSY, 1'b1);
    sb_drain();
    RST = 1'b1;
    tick();
    exp_q.delete();
    exp_cnt = 0;
    model_booted = 1'b0;
    check("midrst_wren", WREN, 1'b0);
    check("midrst_bus", {ABUS, DBUS}, 10'd0);
    check("midrst_busy0", BUSY, 1'b0);
    check("midrst_booted", BOOTED, 1'b0);
    check("midrst_boot_done", BOOT_DONE, 1'b0);
    check("midrst_wr_count", WR_COUNT, 8'd0);
    RST = 1'b0;
    n0 = wr_cyc_q.size();
    repeat (10) tick();
    check("midrst_no_write", wr_cyc_q.size() - n0, 0);
    check("midrst_still_unbooted", BOOTED, 1'b0);
    boot_pulse(t0);
    wait_idle(40);
    check("restart_first_offset", wr_cyc_at(n0) - t0 + 1, 1);
    check("restart_booted", BOOTED, 1'b1);
    check("restart_wr_count", WR_COUNT, 8'd4);
    sb_drain();

    // Random single writes drive WR_COUNT into saturation.
    for (int i = 0; i < 300; i++) begin
      ra = 2'($urandom_range(0, 3));
      rd = 8'($urandom_range(0, 255));
      host_write(ra, rd, ths);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle(20);
    check("saturate", WR_COUNT, 8'hFF);
    sb_drain();
    check("sb_empty", exp_q.size(), 0);
    check("idle_bus_clean", idle_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
